// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants for the key-schedule and cipher blocks:
//   - key, word and round sizing (AES-128 only)
//   - round constant table Rcon[1..10] (byte value, placed in word bits [31:24])
//   - state encoding for the inverse key-schedule stream controller
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_KEY_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_NB     = 4;
    localparam int unsigned AES_NR     = 10;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } aes_ks_state_e;

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational. Shared with the cipher SubBytes.
// Ports:
//   sbox_i  in   8  input byte
//   sbox_o  out  8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] sbox_i,
    output logic [7:0] sbox_o
);

    // Entry 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX_LUT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sbox_o = SBOX_LUT[sbox_i];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_inv_key_schedule
// Reverse AES-128 key schedule. Accepts the round-Nr key and streams round
// keys Nr..0 over a valid/ready interface, one per accepted beat, each step
// undoing the forward expansion.
// Ports:
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous active-low reset
//   i_valid    in   1    last_key valid
//   i_ready    out  1    idle, able to accept a key
//   last_key   in   128  round-Nr key, word j at [32j +: 32]
//   o_valid    out  1    round_key / round_idx valid
//   o_ready    in   1    downstream accepts current beat
//   round_key  out  128  current round key (registered)
//   round_idx  out  4    round number of round_key
//   o_last     out  1    o_valid && round_idx == 0
// ---------------------------------------------------------------------------
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned KEY_LENGTH  = AES_KEY_W,
    parameter int unsigned WORD_LENGTH = AES_WORD_W,
    parameter int unsigned Nr          = AES_NR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [KEY_LENGTH-1:0] last_key,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [KEY_LENGTH-1:0] round_key,
    output logic [3:0]            round_idx,
    output logic                  o_last
);

    localparam int unsigned Nk = KEY_LENGTH / WORD_LENGTH;

    aes_ks_state_e         state_q;
    logic [KEY_LENGTH-1:0] cur_key_q;
    logic [3:0]            idx_q;
    logic                  o_valid_q;
    logic                  o_last_q;
    logic                  i_ready_q;

    logic [WORD_LENGTH-1:0] a_w [Nk];
    logic [WORD_LENGTH-1:0] p0, p1, p2, p3;
    logic [WORD_LENGTH-1:0] rot_w;
    logic [WORD_LENGTH-1:0] sub_w;
    logic [7:0]             rcon;
    logic [KEY_LENGTH-1:0]  step_key_d;

    always_comb begin
        for (int unsigned j = 0; j < Nk; j++) begin
            a_w[j] = cur_key_q[WORD_LENGTH*j +: WORD_LENGTH];
        end
    end

    // Recover w[4r-4..4r-1] from w[4r..4r+3]; p3 is w[4r-1], which feeds
    // the SubWord/RotWord term that produced w[4r].
    assign p3    = a_w[3] ^ a_w[2];
    assign p2    = a_w[2] ^ a_w[1];
    assign p1    = a_w[1] ^ a_w[0];
    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_i (rot_w[8*b +: 8]),
            .sbox_o (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        rcon = '0;
        if (idx_q >= 4'd1 && idx_q <= 4'd10) begin
            rcon = AES_RCON[idx_q];
        end
    end

    assign p0         = a_w[0] ^ sub_w ^ {rcon, 24'h000000};
    assign step_key_d = {p3, p2, p1, p0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cur_key_q <= '0;
            idx_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            i_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        cur_key_q <= last_key;
                        idx_q     <= 4'(Nr);
                        state_q   <= STREAM;
                        o_valid_q <= 1'b1;
                        o_last_q  <= 1'b0;
                        i_ready_q <= 1'b0;
                    end
                end
                STREAM: begin
                    if (o_ready) begin
                        if (idx_q != 4'd0) begin
                            cur_key_q <= step_key_d;
                            idx_q     <= idx_q - 4'd1;
                            o_last_q  <= (idx_q == 4'd1);
                        end else begin
                            state_q   <= IDLE;
                            o_valid_q <= 1'b0;
                            o_last_q  <= 1'b0;
                            i_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ready   = i_ready_q;
    assign o_valid   = o_valid_q;
    assign o_last    = o_last_q;
    assign round_key = cur_key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_schedule
// Directed bench for the reverse AES-128 key schedule. A word-level model of
// the FIPS-197 expansion (S-box derived from GF(2^8) inversion) predicts
// every beat; a compare process checks the outputs each cycle, and the
// stimulus adds literal FIPS-197 expectations.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_schedule;

    logic         clk;
    logic         reset;
    logic         i_valid;
    logic         i_ready;
    logic [127:0] last_key;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         o_last;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] FIPS_KEY  = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
    localparam logic [127:0] FIPS_R1   = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    localparam logic [127:0] FIPS_R0   = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] ZERO_LAST = 128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb;
    localparam logic [127:0] OTHER_KEY = 128'h01234567_89abcdef_fedcba98_76543210;

    aes_inv_key_schedule #(
        .KEY_LENGTH  (128),
        .WORD_LENGTH (32),
        .Nr          (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .last_key  (last_key),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .o_last    (o_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] y8;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            y8 = y[7:0];
            if (gmul(x, y8) == 8'h01) inv = y8;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_m(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < n; k++) rc = xtime(rc);
        return rc;
    endfunction

    function automatic logic [31:0] subword_m(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    // Run the FIPS-197 word recurrence w[i] = w[i-4] ^ temp(w[i-1]) backwards.
    function automatic logic [127:0] model_round(input logic [127:0] lk, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[40+j] = lk[32*j +: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword_m({t[23:0], t[31:24]}) ^ {rcon_m(i/4), 24'h000000};
            w[i-4] = w[i] ^ t;
        end
        return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    bit           exp_active = 1'b0;
    int           exp_idx    = 0;
    logic [127:0] exp_last   = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_o_valid",   {127'b0, o_valid}, 128'd0);
                check("rst_o_last",    {127'b0, o_last},  128'd0);
                check("rst_round_idx", {124'b0, round_idx}, 128'd0);
                check("rst_round_key", round_key, 128'd0);
                exp_active = 1'b0;
            end else begin
                check("o_valid", {127'b0, o_valid}, {127'b0, exp_active});
                check("i_ready", {127'b0, i_ready}, {127'b0, !exp_active});
                if (exp_active) begin
                    check("round_idx", {124'b0, round_idx}, 128'(exp_idx));
                    check("round_key", round_key, model_round(exp_last, exp_idx));
                    check("o_last", {127'b0, o_last}, {127'b0, exp_idx == 0});
                    if (o_ready) begin
                        if (exp_idx == 0) exp_active = 1'b0;
                        else exp_idx--;
                    end
                end else begin
                    check("o_last_idle", {127'b0, o_last}, 128'd0);
                    if (i_valid) begin
                        exp_active = 1'b1;
                        exp_idx    = 10;
                        exp_last   = last_key;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [127:0] k);
        i_valid  = 1'b1;
        last_key = k;
        step();
        i_valid  = 1'b0;
        last_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idx(input logic [3:0] target, output int cycles);
        cycles = 0;
        while (!(o_valid && round_idx == target) && cycles < 40) begin
            step();
            cycles++;
        end
        if (!(o_valid && round_idx == target)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idx%0d: timed out, got idx %0d valid %0b required idx %0d valid 1",
                     target, round_idx, o_valid, target);
        end
    endtask

    initial begin
        int cyc;
        reset    = 1'b1;
        i_valid  = 1'b0;
        o_ready  = 1'b1;
        last_key = '0;
        #1 reset = 1'b0;

        // model pins against FIPS-197 values
        check("model_r1",   model_round(FIPS_KEY, 1), FIPS_R1);
        check("model_r0",   model_round(FIPS_KEY, 0), FIPS_R0);
        check("model_zero", model_round(ZERO_LAST, 0), 128'd0);

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            i_valid  = 1'($urandom);
            o_ready  = 1'($urandom);
            last_key = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        reset   = 1'b1;
        step();
        check("rel_i_ready", {127'b0, i_ready}, 128'd1);

        // 2: FIPS-197 key, o_ready held high
        send_key(FIPS_KEY);
        check("s2_idx10", {124'b0, round_idx}, 128'd10);
        check("s2_key10", round_key, FIPS_KEY);
        wait_idx(4'd1, cyc);
        check("s2_cycles", 128'(cyc), 128'd9);
        check("s2_key1", round_key, FIPS_R1);
        // a key offered with the last beat must not be taken
        i_valid  = 1'b1;
        last_key = ZERO_LAST;
        step();
        check("s2_idx0",  {124'b0, round_idx}, 128'd0);
        check("s2_key0",  round_key, FIPS_R0);
        check("s2_last0", {127'b0, o_last}, 128'd1);
        step();
        i_valid = 1'b0;
        check("s2_after_valid", {127'b0, o_valid}, 128'd0);
        check("s2_after_ready", {127'b0, i_ready}, 128'd1);

        // 3: key derived from the all-zero cipher key
        send_key(ZERO_LAST);
        wait_idx(4'd0, cyc);
        check("s3_key0",  round_key, 128'd0);
        check("s3_last0", {127'b0, o_last}, 128'd1);
        step();

        // 4: backpressure at idx 5
        send_key(FIPS_KEY);
        wait_idx(4'd5, cyc);
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s4_hold_idx", {124'b0, round_idx}, 128'd5);
            check("s4_hold_key", round_key, model_round(FIPS_KEY, 5));
            check("s4_hold_valid", {127'b0, o_valid}, 128'd1);
        end
        o_ready = 1'b1;
        step();
        check("s4_resume_idx", {124'b0, round_idx}, 128'd4);
        wait_idx(4'd0, cyc);
        check("s4_key0", round_key, FIPS_R0);
        step();

        // 5: i_valid pulse while streaming
        send_key(FIPS_KEY);
        wait_idx(4'd7, cyc);
        i_valid  = 1'b1;
        last_key = OTHER_KEY;
        check("s5_i_ready", {127'b0, i_ready}, 128'd0);
        step();
        i_valid = 1'b0;
        wait_idx(4'd1, cyc);
        check("s5_key1", round_key, FIPS_R1);
        step();
        check("s5_key0", round_key, FIPS_R0);
        step();

        // 6: reset mid-stream
        send_key(FIPS_KEY);
        wait_idx(4'd6, cyc);
        #2 reset = 1'b0;
        #1 check("s6_async_valid", {127'b0, o_valid}, 128'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("s6_rel_ready", {127'b0, i_ready}, 128'd1);
        check("s6_rel_valid", {127'b0, o_valid}, 128'd0);
        send_key(FIPS_KEY);
        check("s6_idx10", {124'b0, round_idx}, 128'd10);
        check("s6_key10", round_key, FIPS_KEY);
        wait_idx(4'd0, cyc);
        check("s6_key0", round_key, FIPS_R0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Reverse AES-128 key schedule for the decryption datapath. Accepts the final round key (w40..w43) and streams round keys in descending order, round Nr down to round 0, one per accepted beat. Each step is computed by inverting the forward expansion. It is the counterpart to the forward schedule loader: same word packing, opposite direction. It feeds the inverse-cipher round engine through a valid/ready stream.

Parameters:
KEY_LENGTH, 128, key and round-key width in bits (only 128 supported)
WORD_LENGTH, 32, schedule word width
Nk, KEY_LENGTH/WORD_LENGTH, words per round key (4)
Nr, 10, number of rounds; first emitted round index

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
i_valid  input  1  last_key is valid
i_ready  output  1  block idle and able to accept a key
last_key  input  KEY_LENGTH  round-Nr key; word j at bits [32j +: 32]
o_valid  output  1  round_key/round_idx valid
o_ready  input  1  downstream accepts current beat
round_key  output  KEY_LENGTH  current round key, same packing as last_key
round_idx  output  4  round number of round_key (Nr..0)
o_last  output  1  o_valid && round_idx==0

Behaviour:
- Word format: byte 0 of word in [31:24]. RotWord(x) = {x[23:0], x[31:24]}. Rcon byte sits in [31:24] with the lower 24 bits zero.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Inverse step from round r (words a0..a3 = w4r..w4r+3) to round r-1:
  - p3 = a3^a2
  - p2 = a2^a1
  - p1 = a1^a0
  - p0 = a0 ^ SubWord(RotWord(p3)) ^ Rcon[r]
  - The step is purely combinational within one cycle.
- FSM states:
  - IDLE: i_ready=1, o_valid=0. When i_valid=1, load cur_key <= last_key and round_idx <= Nr, then go to STREAM.
  - STREAM: i_ready=0, o_valid=1, round_key=cur_key.
    - On o_ready=1 with round_idx!=0: cur_key <= inv_step(cur_key, Rcon[round_idx]) and round_idx <= round_idx-1.
    - On o_ready=1 with round_idx==0: go to IDLE and drive o_valid to 0 next cycle.
- Latency: the first beat (round Nr) is valid one cycle after the accept. With o_ready held high, 11 beats take 11 consecutive cycles. A new key can be accepted no earlier than one cycle after the last beat, so the minimum period is 12 cycles per key.
- Backpressure: while o_valid=1 and o_ready=0, round_key, round_idx, o_last and o_valid hold stable.
- i_valid while in STREAM is ignored (i_ready=0); cur_key is not disturbed.
- Simultaneous i_valid and the last-beat handshake: the key is not accepted. Acceptance happens only in IDLE.
- Reset (asynchronous, active-low): state=IDLE, cur_key=0, round_idx=0, o_valid=0, o_last=0, i_ready=1 after release.
  - Reset mid-stream aborts the sequence immediately.
  - No partial beats are emitted after release.
- round_key is a direct register output, with no combinational path from inputs.

Decomposition:
- Shared package aes_pkg holds:
  - AES_KEY_W=128, AES_WORD_W=32, AES_NB=4, AES_NR=10
  - the Rcon constant array indexed 1..10
  - the state encoding (IDLE, STREAM)
- One natural sub-module: aes_sbox (8-bit combinational forward S-box), instantiated 4x to form SubWord. It is shared with the cipher's SubBytes.
- The RTL contains the FSM, counter, step datapath and Rcon mux.

Test Plan:
1. Reset check: assert reset=0 with random inputs -> o_valid=0, o_last=0, round_idx=0, round_key=0; after release i_ready=1.
2. FIPS-197 key: last_key=128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8 with o_ready=1 ->
   - 11 consecutive beats, idx 10..0
   - idx 10 = that same value
   - idx 1 = 128'h2a6c7605_23a33939_88542cb1_a0fafe17
   - idx 0 = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516 with o_last=1
   - o_valid=0 the next cycle
3. Zero key: last_key=128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb -> idx 0 beat = 128'h0 with o_last=1.
4. Backpressure: drop o_ready for 3 cycles while idx=5 -> round_key/round_idx are unchanged over those cycles; the sequence resumes with idx 4 and the final keys match scenario 2.
5. Busy input: pulse i_valid with a different key during idx 7 -> i_ready=0, the pulse is ignored, and the output sequence is identical to scenario 2.
6. Mid-stream reset: assert reset at idx 6 -> o_valid drops asynchronously. After release, i_ready=1, and a new scenario-2 key restarts at idx 10.
